// File: rtl/usb_host_auth_agent.sv
// Host-side authentication agent: sequences Type-C CC attach/detach with
// debounce and orientation, and answers controller authentication requests
// from a programmable response table after a configurable latency.
module usb_host_auth_agent #(
  parameter int unsigned MSG_LEN    = 2080,
  parameter int unsigned NUM_SLOTS  = 4,
  parameter int unsigned ATTACH_DLY = 16,
  parameter int unsigned RESP_DLY   = 8,
  parameter int unsigned CC_FLIP    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         attach_en,
  output logic                         CC1,
  output logic                         CC2,
  input  logic                         resp_req_out,
  input  logic [MSG_LEN-1:0]           auth_msg_resp_out,
  output logic                         Ack_out_resp,
  output logic [MSG_LEN-1:0]           auth_msg_resp_in,
  output logic                         resp_req_in,
  input  logic                         resp_taken,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr,
  input  logic [MSG_LEN-1:0]           cfg_data,
  output logic                         err_unsup
);

  localparam int unsigned IDX_W   = $clog2(NUM_SLOTS);
  localparam int unsigned CNT_MAX = (ATTACH_DLY > RESP_DLY) ? ATTACH_DLY : RESP_DLY;
  localparam int unsigned CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] ATT_LAST  = CNT_W'((ATTACH_DLY > 0) ? ATTACH_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_DLY);
  localparam logic [7:0]       CODE_BASE = 8'h81;
  localparam logic [7:0]       CODE_TOP  = 8'(128 + NUM_SLOTS);
  localparam logic [MSG_LEN-1:0] ERR_MSG =
    {8'h01, 8'h7F, 8'h01, 8'h00, {(MSG_LEN-32){1'b0}}};

  typedef enum logic [1:0] {DETACHED, DEBOUNCE, ATTACHED} att_state_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} resp_state_t;

  att_state_t       att_state;
  resp_state_t      resp_state;
  logic [CNT_W-1:0] att_cnt;
  logic [CNT_W-1:0] resp_cnt;
  logic [7:0]       req_code;
  logic [7:0]       code_off;
  logic [IDX_W-1:0] code_idx;
  logic             code_ok;
  logic             link_up;
  logic             cfg_ok;
  logic             unused_bits;

  logic [MSG_LEN-1:0] resp_tbl [NUM_SLOTS];

  // Link is considered up only while attached and attach_en is still held,
  // so a detach edge aborts a pending response in the same cycle CC drops.
  assign link_up  = (att_state == ATTACHED) && attach_en;
  assign code_off = req_code - CODE_BASE;
  assign code_idx = code_off[IDX_W-1:0];
  assign code_ok  = (req_code >= CODE_BASE) && (req_code <= CODE_TOP);

  // Only byte 1 of the request carries information for this agent.
  assign unused_bits = ^{auth_msg_resp_out[MSG_LEN-1 -: 8],
                         auth_msg_resp_out[MSG_LEN-17:0],
                         code_off[7:IDX_W]};

  // Every address of a power-of-two table is valid; otherwise range-check.
  if (NUM_SLOTS == (1 << IDX_W)) begin : g_addr_full
    assign cfg_ok = 1'b1;
  end else begin : g_addr_chk
    assign cfg_ok = (cfg_addr < IDX_W'(NUM_SLOTS));
  end

  // Response table write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ok) begin
      resp_tbl[cfg_addr] <= cfg_data;
    end
  end

  // Attach FSM: debounce attach_en, drive CC per orientation, instant detach.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      att_state <= DETACHED;
      att_cnt   <= '0;
      CC1       <= 1'b0;
      CC2       <= 1'b0;
    end else begin
      case (att_state)
        DETACHED: begin
          att_cnt <= '0;
          if (attach_en) begin
            att_state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!attach_en) begin
            att_state <= DETACHED;
            att_cnt   <= '0;
          end else if (att_cnt == ATT_LAST) begin
            att_state <= ATTACHED;
            CC1       <= (CC_FLIP == 0);
            CC2       <= (CC_FLIP != 0);
          end else if (att_cnt != '1) begin
            att_cnt <= att_cnt + 1'b1;
          end
        end
        ATTACHED: begin
          if (!attach_en) begin
            att_state <= DETACHED;
            att_cnt   <= '0;
            CC1       <= 1'b0;
            CC2       <= 1'b0;
          end
        end
        default: begin
          att_state <= DETACHED;
          att_cnt   <= '0;
          CC1       <= 1'b0;
          CC2       <= 1'b0;
        end
      endcase
    end
  end

  // Response FSM: capture request, wait RESP_DLY, present response until
  // taken, then drain until the request level drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_state       <= IDLE;
      resp_cnt         <= '0;
      req_code         <= '0;
      Ack_out_resp     <= 1'b0;
      resp_req_in      <= 1'b0;
      auth_msg_resp_in <= '0;
      err_unsup        <= 1'b0;
    end else begin
      Ack_out_resp <= 1'b0;
      err_unsup    <= 1'b0;
      case (resp_state)
        IDLE: begin
          if (link_up && resp_req_out) begin
            req_code     <= auth_msg_resp_out[MSG_LEN-9 -: 8];
            Ack_out_resp <= 1'b1;
            resp_cnt     <= '0;
            resp_state   <= WAIT;
          end
        end
        WAIT: begin
          if (!link_up) begin
            resp_state <= IDLE;
          end else if (resp_cnt == RESP_LAST) begin
            resp_state  <= RESP;
            resp_req_in <= 1'b1;
            if (code_ok) begin
              auth_msg_resp_in <= resp_tbl[code_idx];
            end else begin
              auth_msg_resp_in <= ERR_MSG;
              err_unsup        <= 1'b1;
            end
          end else if (resp_cnt != '1) begin
            resp_cnt <= resp_cnt + 1'b1;
          end
        end
        RESP: begin
          if (!link_up) begin
            resp_req_in <= 1'b0;
            resp_state  <= IDLE;
          end else if (resp_taken) begin
            resp_req_in <= 1'b0;
            resp_state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!link_up || !resp_req_out) begin
            resp_state <= IDLE;
          end
        end
        default: begin
          resp_state  <= IDLE;
          resp_req_in <= 1'b0;
        end
      endcase
    end
  end

endmodule
